// File: rtl/parallel_mul_twiddle_fft4.sv
// parallel_mul_twiddle_fft4: last radix-4 stage of an 8192-point DIT FFT.
// Latency 4 clocks (register, twiddle products, complex add, butterfly+truncate).
// No back-pressure: the pipeline advances every clock; valid/lable ride alongside as ready/index.
module parallel_mul_twiddle_fft4 #(
  parameter int DATA_WIDTH = 21,
  parameter int TWID_WIDTH = 16,
  parameter int MSB_CUTOFF = 26,
  parameter int LSB_CUTOFF = 12,
  parameter int SHIFT      = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid,
  input  logic [10:0]                  lable,
  input  logic signed [DATA_WIDTH-1:0] x0_r,
  input  logic signed [DATA_WIDTH-1:0] x0_i,
  input  logic signed [DATA_WIDTH-1:0] x1_r,
  input  logic signed [DATA_WIDTH-1:0] x1_i,
  input  logic signed [DATA_WIDTH-1:0] x2_r,
  input  logic signed [DATA_WIDTH-1:0] x2_i,
  input  logic signed [DATA_WIDTH-1:0] x3_r,
  input  logic signed [DATA_WIDTH-1:0] x3_i,
  output logic signed [MSB_CUTOFF:0]   y0_r,
  output logic signed [MSB_CUTOFF:0]   y0_i,
  output logic signed [MSB_CUTOFF:0]   y1_r,
  output logic signed [MSB_CUTOFF:0]   y1_i,
  output logic signed [MSB_CUTOFF:0]   y2_r,
  output logic signed [MSB_CUTOFF:0]   y2_i,
  output logic signed [MSB_CUTOFF:0]   y3_r,
  output logic signed [MSB_CUTOFF:0]   y3_i,
  output logic [10:0]                  index,
  output logic                         ready
);
  localparam int PW = DATA_WIDTH + TWID_WIDTH;   // real product width
  localparam int AW = PW + 1;                    // complex product width
  localparam int BW = PW + 2;                    // butterfly sum width
  localparam int OW = MSB_CUTOFF + 1;
  localparam int MW = TWID_WIDTH + 1;            // magnitude incl. exact 1.0
  localparam int QN = 2048;                      // quarter wave of 8192 points
  localparam logic signed [MW:0] WMAX = (MW+1)'((1 << (TWID_WIDTH - 1)) - 1);

  // Rounded magnitude of cos(2*pi*r/8192) scaled to 2^SHIFT, r in 0..QN.
  function automatic logic [MW-1:0] quarter_mag(input int r);
    real v;
    v = $cos(2.0 * 3.14159265358979323846 * r / 8192.0) * (1 << SHIFT);
    return MW'($rtoi(v + 0.5));
  endfunction

  // Apply sign to a magnitude and clip +1.0 to the largest positive code.
  function automatic logic signed [TWID_WIDTH-1:0] signed_comp(input logic [MW-1:0] mag_v,
                                                               input logic neg);
    logic signed [MW:0] v;
    v = $signed({1'b0, mag_v});
    if (neg) v = -v;
    if (v > WMAX) v = WMAX;
    return v[TWID_WIDTH-1:0];
  endfunction

  logic [MW-1:0] mag [0:QN];
  for (genvar g = 0; g <= QN; g++) begin : g_tab
    localparam logic [MW-1:0] MAG = quarter_mag(g);
    assign mag[g] = MAG;
  end

  // Stage 1 registers
  logic                         s1_vld;
  logic [10:0]                  s1_lbl;
  logic signed [DATA_WIDTH-1:0] s1_xr [0:3];
  logic signed [DATA_WIDTH-1:0] s1_xi [0:3];

  // Stage 1: capture the input group as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_lbl <= '0;
      for (int m = 0; m < 4; m++) begin
        s1_xr[m] <= '0;
        s1_xi[m] <= '0;
      end
    end else begin
      s1_vld   <= valid;
      s1_lbl   <= lable;
      s1_xr[0] <= x0_r;
      s1_xi[0] <= x0_i;
      s1_xr[1] <= x1_r;
      s1_xi[1] <= x1_i;
      s1_xr[2] <= x2_r;
      s1_xi[2] <= x2_i;
      s1_xr[3] <= x3_r;
      s1_xi[3] <= x3_i;
    end
  end

  // Twiddle lookup: quadrant of e = m*lable selects cos/sin from the quarter table.
  logic signed [TWID_WIDTH-1:0] tw_r [1:3];
  logic signed [TWID_WIDTH-1:0] tw_i [1:3];
  for (genvar m = 1; m <= 3; m++) begin : g_tw
    logic [12:0]   e;
    logic [1:0]    q;
    logic [11:0]   idx_c;
    logic [11:0]   idx_s;
    logic [MW-1:0] mag_c;
    logic [MW-1:0] mag_s;
    assign e     = 13'(m) * {2'b00, s1_lbl};
    assign q     = e[12:11];
    assign idx_c = {1'b0, e[10:0]};
    assign idx_s = 12'(QN) - idx_c;
    assign mag_c = mag[idx_c];
    assign mag_s = mag[idx_s];
    // wr = cos: negative in quadrants 1,2; wi = -sin: negative in quadrants 0,1.
    assign tw_r[m] = signed_comp(q[0] ? mag_s : mag_c, q[0] ^ q[1]);
    assign tw_i[m] = signed_comp(q[0] ? mag_c : mag_s, ~q[1]);
  end

  // Stage 2 registers
  logic                         s2_vld;
  logic [10:0]                  s2_lbl;
  logic signed [DATA_WIDTH-1:0] s2_x0r;
  logic signed [DATA_WIDTH-1:0] s2_x0i;
  logic signed [PW-1:0]         p_rr [1:3];
  logic signed [PW-1:0]         p_ii [1:3];
  logic signed [PW-1:0]         p_ri [1:3];
  logic signed [PW-1:0]         p_ir [1:3];

  // Stage 2: the four real products of each twiddled sample; x0 just passes through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_lbl <= '0;
      s2_x0r <= '0;
      s2_x0i <= '0;
      for (int m = 1; m <= 3; m++) begin
        p_rr[m] <= '0;
        p_ii[m] <= '0;
        p_ri[m] <= '0;
        p_ir[m] <= '0;
      end
    end else begin
      s2_vld <= s1_vld;
      s2_lbl <= s1_lbl;
      s2_x0r <= s1_xr[0];
      s2_x0i <= s1_xi[0];
      for (int m = 1; m <= 3; m++) begin
        p_rr[m] <= PW'(s1_xr[m]) * PW'(tw_r[m]);
        p_ii[m] <= PW'(s1_xi[m]) * PW'(tw_i[m]);
        p_ri[m] <= PW'(s1_xr[m]) * PW'(tw_i[m]);
        p_ir[m] <= PW'(s1_xi[m]) * PW'(tw_r[m]);
      end
    end
  end

  // Stage 3 registers
  logic                 s3_vld;
  logic [10:0]          s3_lbl;
  logic signed [AW-1:0] a_r [0:3];
  logic signed [AW-1:0] a_i [0:3];

  // Stage 3: complex products; x0 is scaled by 2^SHIFT to match twiddle scaling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_vld <= 1'b0;
      s3_lbl <= '0;
      for (int m = 0; m < 4; m++) begin
        a_r[m] <= '0;
        a_i[m] <= '0;
      end
    end else begin
      s3_vld <= s2_vld;
      s3_lbl <= s2_lbl;
      a_r[0] <= AW'(s2_x0r) <<< SHIFT;
      a_i[0] <= AW'(s2_x0i) <<< SHIFT;
      for (int m = 1; m <= 3; m++) begin
        a_r[m] <= AW'(p_rr[m]) - AW'(p_ii[m]);
        a_i[m] <= AW'(p_ri[m]) + AW'(p_ir[m]);
      end
    end
  end

  logic signed [BW-1:0] e_r [0:3];
  logic signed [BW-1:0] e_i [0:3];
  logic signed [BW-1:0] b_r [0:3];
  logic signed [BW-1:0] b_i [0:3];

  // Radix-4 butterfly at full precision; multiply by j maps (r,i) to (-i,r).
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      e_r[k] = BW'(a_r[k]);
      e_i[k] = BW'(a_i[k]);
    end
    b_r[0] = e_r[0] + e_r[1] + e_r[2] + e_r[3];
    b_i[0] = e_i[0] + e_i[1] + e_i[2] + e_i[3];
    b_r[1] = e_r[0] + e_i[1] - e_r[2] - e_i[3];
    b_i[1] = e_i[0] - e_r[1] - e_i[2] + e_r[3];
    b_r[2] = e_r[0] - e_r[1] + e_r[2] - e_r[3];
    b_i[2] = e_i[0] - e_i[1] + e_i[2] - e_i[3];
    b_r[3] = e_r[0] - e_i[1] - e_r[2] + e_i[3];
    b_i[3] = e_i[0] + e_r[1] - e_i[2] - e_r[3];
  end

  // Stage 4: floor-shift and truncate into the output register (no saturation needed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_r  <= '0;
      y0_i  <= '0;
      y1_r  <= '0;
      y1_i  <= '0;
      y2_r  <= '0;
      y2_i  <= '0;
      y3_r  <= '0;
      y3_i  <= '0;
      index <= '0;
      ready <= 1'b0;
    end else begin
      y0_r  <= OW'(b_r[0] >>> LSB_CUTOFF);
      y0_i  <= OW'(b_i[0] >>> LSB_CUTOFF);
      y1_r  <= OW'(b_r[1] >>> LSB_CUTOFF);
      y1_i  <= OW'(b_i[1] >>> LSB_CUTOFF);
      y2_r  <= OW'(b_r[2] >>> LSB_CUTOFF);
      y2_i  <= OW'(b_i[2] >>> LSB_CUTOFF);
      y3_r  <= OW'(b_r[3] >>> LSB_CUTOFF);
      y3_i  <= OW'(b_i[3] >>> LSB_CUTOFF);
      index <= s3_lbl;
      ready <= s3_vld;
    end
  end

endmodule

// File: tb/tb_parallel_mul_twiddle_fft4.sv
// Bench for parallel_mul_twiddle_fft4: directed groups with hand-computed results,
// a full 2048-label stream against an arithmetic model, and async reset checks.
// Stimulus pushes expectations; a negedge monitor pops and compares on ready.
module tb_parallel_mul_twiddle_fft4;
  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               valid = 1'b0;
  logic [10:0]        lable = '0;
  logic signed [20:0] x0_r = '0, x0_i = '0, x1_r = '0, x1_i = '0;
  logic signed [20:0] x2_r = '0, x2_i = '0, x3_r = '0, x3_i = '0;
  logic signed [26:0] y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i;
  logic [10:0]        index;
  logic               ready;

  parallel_mul_twiddle_fft4 dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .lable(lable),
    .x0_r(x0_r), .x0_i(x0_i), .x1_r(x1_r), .x1_i(x1_i),
    .x2_r(x2_r), .x2_i(x2_i), .x3_r(x3_r), .x3_i(x3_i),
    .y0_r(y0_r), .y0_i(y0_i), .y1_r(y1_r), .y1_i(y1_i),
    .y2_r(y2_r), .y2_i(y2_i), .y3_r(y3_r), .y3_i(y3_i),
    .index(index), .ready(ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    longint y[8];   // y0_r, y0_i, y1_r, ... y3_i
    int     idx;
    int     issue;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   rdy_cnt = 0;
  int   z[4] = '{0, 0, 0, 0};

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint outv(input int j);
    case (j)
      0: return longint'(y0_r);
      1: return longint'(y0_i);
      2: return longint'(y1_r);
      3: return longint'(y1_i);
      4: return longint'(y2_r);
      5: return longint'(y2_i);
      6: return longint'(y3_r);
      default: return longint'(y3_i);
    endcase
  endfunction

  // Twiddle component straight from the definition: round-half-away, clipped.
  function automatic longint twq(input int e, input bit im);
    real    ang, v;
    longint q;
    ang = 2.0 * 3.14159265358979323846 * e / 8192.0;
    v = (im ? -$sin(ang) : $cos(ang)) * 32768.0;
    if (v >= 0.0) q = longint'($floor(v + 0.5));
    else          q = -longint'($floor(-v + 0.5));
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  function automatic longint out27(input longint s);
    logic signed [26:0] t;
    t = 27'(s >>> 12);
    return longint'(t);
  endfunction

  function automatic exp_t model(input int k, input int xr[4], input int xi[4]);
    longint ar[4], ai[4], br[4], bi[4];
    longint wr, wi;
    exp_t   e;
    ar[0] = longint'(xr[0]) * 32768;
    ai[0] = longint'(xi[0]) * 32768;
    for (int m = 1; m < 4; m++) begin
      wr = twq(m * k, 1'b0);
      wi = twq(m * k, 1'b1);
      ar[m] = longint'(xr[m]) * wr - longint'(xi[m]) * wi;
      ai[m] = longint'(xr[m]) * wi + longint'(xi[m]) * wr;
    end
    br[0] = ar[0] + ar[1] + ar[2] + ar[3];
    bi[0] = ai[0] + ai[1] + ai[2] + ai[3];
    br[1] = ar[0] + ai[1] - ar[2] - ai[3];
    bi[1] = ai[0] - ar[1] - ai[2] + ar[3];
    br[2] = ar[0] - ar[1] + ar[2] - ar[3];
    bi[2] = ai[0] - ai[1] + ai[2] - ai[3];
    br[3] = ar[0] - ai[1] - ar[2] + ai[3];
    bi[3] = ai[0] + ar[1] - ai[2] - ar[3];
    for (int j = 0; j < 4; j++) begin
      e.y[2*j]   = out27(br[j]);
      e.y[2*j+1] = out27(bi[j]);
    end
    e.idx   = k;
    e.issue = 0;
    return e;
  endfunction

  function automatic exp_t hand(input int k, input longint a0, input longint a1, input longint a2,
                                input longint a3, input longint a4, input longint a5,
                                input longint a6, input longint a7);
    exp_t e;
    e.y = '{a0, a1, a2, a3, a4, a5, a6, a7};
    e.idx   = k;
    e.issue = 0;
    return e;
  endfunction

  // Deterministic 21-bit signed pattern spread over the whole range.
  function automatic int pat(input int k, input int s);
    int v;
    if (k == 0) return -(1 << 20);
    if (k == 1) return (1 << 20) - 1;
    v = (k * 7919 + s * 104729 + 12345) & 32'h1FFFFF;
    return (v >= 32'h100000) ? v - 32'h200000 : v;
  endfunction

  task automatic drive(input bit v, input int k, input int xr[4], input int xi[4]);
    @(negedge clk);
    valid = v;
    lable = 11'(k);
    x0_r = 21'(xr[0]); x0_i = 21'(xi[0]);
    x1_r = 21'(xr[1]); x1_i = 21'(xi[1]);
    x2_r = 21'(xr[2]); x2_i = 21'(xi[2]);
    x3_r = 21'(xr[3]); x3_i = 21'(xi[3]);
  endtask

  task automatic send(input int k, input int xr[4], input int xi[4], input exp_t e);
    drive(1'b1, k, xr, xi);
    e.issue = cyc;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, z, z);
  endtask

  task automatic drain();
    int budget;
    budget = 30;
    while (sb.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    check_eq("drain_empty", sb.size(), 0);
    idle(2);
  endtask

  // Monitor: every ready cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ready) begin
      rdy_cnt++;
      check_eq("ready_expected", longint'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int j = 0; j < 8; j++)
          check_eq($sformatf("y%0d_%s k=%0d", j / 2, (j % 2) ? "i" : "r", e.idx), outv(j), e.y[j]);
        check_eq("index", longint'(index), e.idx);
        check_eq("latency", cyc - e.issue, 4);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_total);
    $fatal(1);
  end

  initial begin
    int xr[4], xi[4];
    // Reset held with a busy, valid input group.
    valid = 1'b1; lable = 11'd5;
    x0_r = 21'sd77; x1_r = -21'sd5; x2_i = 21'sd300; x3_r = 21'sd1000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 8; j++) check_eq($sformatf("rst_y%0d", j), outv(j), 0);
    check_eq("rst_index", longint'(index), 0);
    check_eq("rst_ready", longint'(ready), 0);
    valid = 1'b0;
    rst_n = 1'b1;
    idle(6);
    check_eq("idle_ready", longint'(ready), 0);

    // Impulse: a0 = 2^15, every output real part = 8.
    xr = '{1, 0, 0, 0};
    send(0, xr, z, hand(0, 8, 0, 8, 0, 8, 0, 8, 0));
    idle(2);
    // DC at lable 0.
    xr = '{1000, 1000, 1000, 1000};
    send(0, xr, z, hand(0, 31999, 0, 0, 0, 0, 0, 0, 0));
    idle(1);
    // x2 through W^2048 = -j.
    xr = '{0, 0, 4096, 0};
    send(1024, xr, z, hand(1024, 0, -32768, 0, 32768, 0, -32768, 0, 32768));
    // Negative floor, back to back with the previous group.
    xr = '{-1, 0, 0, 0};
    send(0, xr, z, hand(0, -8, 0, -8, 0, -8, 0, -8, 0));
    xr = '{-1, 1, 0, 0};
    send(0, xr, z, hand(0, -1, 0, -8, -8, -16, 0, -8, 7));
    drain();

    // Full label sweep, valid held high.
    rdy_cnt = 0;
    for (int k = 0; k < 2048; k++) begin
      for (int m = 0; m < 4; m++) begin
        xr[m] = pat(k, m);
        xi[m] = pat(k, m + 4);
      end
      send(k, xr, xi, model(k, xr, xi));
    end
    drain();
    check_eq("stream_ready_cycles", rdy_cnt, 2048);

    // Mid-stream asynchronous reset.
    for (int k = 0; k < 8; k++) begin
      for (int m = 0; m < 4; m++) begin
        xr[m] = pat(k + 300, m);
        xi[m] = pat(k + 300, m + 4);
      end
      send(300 + k, xr, xi, model(300 + k, xr, xi));
    end
    @(posedge clk);
    #2;
    check_eq("pre_rst_ready", longint'(ready), 1);
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    for (int j = 0; j < 8; j++) check_eq($sformatf("async_rst_y%0d", j), outv(j), 0);
    check_eq("async_rst_index", longint'(index), 0);
    check_eq("async_rst_ready", longint'(ready), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int m = 0; m < 4; m++) begin
        xr[m] = pat(k + 900, m);
        xi[m] = pat(k + 900, m + 4);
      end
      send(900 + k, xr, xi, model(900 + k, xr, xi));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
